// File: rtl/cameralink_pkg.sv
// cameralink_pkg: shared FSM states, frame counter width and bus word packing
package cameralink_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACTIVE, ST_HBLANK, ST_VBLANK} cl_state_e;

   localparam int CL_FRAME_W = 16;
   localparam int CL_PIX_MAX = 64;

   function automatic logic [CL_PIX_MAX+2:0] cl_pack(input logic fvv, input logic lvv, input logic vce,
                                                     input logic [CL_PIX_MAX-1:0] pix, input logic [6:0] pix_w);
      logic [CL_PIX_MAX+2:0] w;
      w = {3'b000, pix};
      w[pix_w +: 3] = {fvv, lvv, vce};
      return w;
   endfunction

endpackage

// File: rtl/cameralink_trigger.sv
// cameralink_trigger: rising-edge trigger capture with a single-deep pending flag
module cameralink_trigger (
   input  logic CLOCK,
   input  logic RESET,
   input  logic cam_request,
   input  logic enable_trig,
   input  logic consume,
   output logic pending,
   output logic overrun
);

   logic req_q, pend_q, ovr_q, rise;

   assign rise = enable_trig && cam_request && !req_q;

   // a rise arriving as the pending trigger is consumed becomes the next pending one
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         req_q  <= 1'b0;
         pend_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         req_q  <= cam_request;
         pend_q <= consume ? rise : (pend_q || rise);
         ovr_q  <= rise && pend_q && !consume;
      end
   end

   assign pending = pend_q;
   assign overrun = ovr_q;

endmodule

// File: rtl/cameralink_frame_gen.sv
// cameralink_frame_gen: CameraLink FVV/LVV/VCE timing and pixel packing from a valid/ready stream
module cameralink_frame_gen import cameralink_pkg::*; #(
   parameter int TAPS      = 3,
   parameter int BITS      = 8,
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int FV_SETUP  = 4,
   parameter int HBLANK    = 16,
   parameter int VBLANK    = 32,
   parameter int TRIGGERED = 0
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic                   in_valid,
   input  logic [TAPS*BITS-1:0]   in_data,
   output logic                   in_ready,
   input  logic                   cam_enable,
   input  logic                   cam_request,
   output logic                   FVV,
   output logic                   LVV,
   output logic                   VCE,
   output logic [TAPS*BITS-1:0]   pix_out,
   output logic [CL_FRAME_W-1:0]  frame_count,
   output logic                   underrun,
   output logic                   trig_overrun
);

   localparam int TM_MAX = FV_SETUP > HBLANK ? (FV_SETUP > VBLANK ? FV_SETUP : VBLANK)
                                             : (HBLANK > VBLANK ? HBLANK : VBLANK);
   localparam int TM_W = $clog2(TM_MAX + 1);
   localparam int PX_W = $clog2(WIDTH + 1);
   localparam int LN_W = $clog2(HEIGHT + 1);

   cl_state_e              state_q;
   logic [TM_W-1:0]        tm_q;
   logic [PX_W-1:0]        px_q;
   logic [LN_W-1:0]        ln_q;
   logic                   fvv_q, lvv_q, vce_q, und_q;
   logic [TAPS*BITS-1:0]   pix_q;
   logic [CL_FRAME_W-1:0]  fc_q;
   logic                   hs, go, tm_end, consume, pending;

   assign in_ready = state_q == ST_ACTIVE;
   assign hs       = in_ready && in_valid;
   assign go       = cam_enable && (TRIGGERED == 0 || pending);
   assign tm_end   = tm_q == TM_W'(state_q == ST_SETUP  ? FV_SETUP - 1 :
                                   state_q == ST_HBLANK ? HBLANK - 1 : VBLANK - 1);
   assign consume  = go && (state_q == ST_IDLE || (state_q == ST_VBLANK && tm_end));

   cameralink_trigger u_trig (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .cam_request (cam_request),
      .enable_trig (TRIGGERED != 0),
      .consume     (consume),
      .pending     (pending),
      .overrun     (trig_overrun)
   );

   // frame sequencer; outputs are registered from the current state so they stay aligned
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         tm_q    <= '0;
         px_q    <= '0;
         ln_q    <= '0;
         fvv_q   <= 1'b0;
         lvv_q   <= 1'b0;
         vce_q   <= 1'b0;
         und_q   <= 1'b0;
         pix_q   <= '0;
         fc_q    <= '0;
      end else begin
         fvv_q <= state_q inside {ST_SETUP, ST_ACTIVE, ST_HBLANK};
         lvv_q <= in_ready;
         vce_q <= hs;
         pix_q <= hs ? in_data : '0;
         und_q <= in_ready && !in_valid;
         tm_q  <= '0;
         case (state_q)
            ST_IDLE:   if (go) state_q <= ST_SETUP;
            ST_SETUP:  if (tm_end) state_q <= ST_ACTIVE; else tm_q <= tm_q + 1'b1;
            ST_ACTIVE: if (hs) begin
               if (px_q == PX_W'(WIDTH - TAPS)) begin
                  px_q    <= '0;
                  state_q <= ln_q == LN_W'(HEIGHT - 1) ? ST_VBLANK : ST_HBLANK;
               end else px_q <= px_q + PX_W'(TAPS);
            end
            ST_HBLANK: if (tm_end) begin
               ln_q    <= ln_q + 1'b1;
               state_q <= ST_ACTIVE;
            end else tm_q <= tm_q + 1'b1;
            ST_VBLANK: if (tm_end) begin
               fc_q    <= fc_q + 1'b1;
               ln_q    <= '0;
               state_q <= go ? ST_SETUP : ST_IDLE;
            end else tm_q <= tm_q + 1'b1;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign FVV         = fvv_q;
   assign LVV         = lvv_q;
   assign VCE         = vce_q;
   assign pix_out     = pix_q;
   assign frame_count = fc_q;
   assign underrun    = und_q;

endmodule
